// File: rtl/uart_mem_loader_pkg.sv
// Shared types and constants for the UART-to-data-memory loader.
package uart_mem_loader_pkg;

  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {L_IDLE, L_LOAD, L_CHK, L_DONE}   ld_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// UART 8N1 byte receiver: rx synchronizer, bit timer, RX FSM and shift register.
// Emits a one-cycle byte_valid pulse, or a one-cycle stop_err pulse on a low stop bit.
module uart_rx_byte
  import uart_mem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic              byte_valid,
  output logic [BYTE_W-1:0] byte_data,
  output logic              stop_err
);

  localparam int              CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  logic              rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              byte_valid_q, byte_valid_d;
  logic              stop_err_q, stop_err_d;

  // NOTE: the synchronizer resets to the idle-high line level so leaving reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // NOTE: every always_comb output gets its default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    stop_err_d   = 1'b0;
    unique case (state_q)
      R_IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) state_d = R_START;
      end
      R_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_sync_q ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          shift_d   = {rx_sync_q, shift_q[BYTE_W-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = R_STOP;
        end
      end
      R_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d        = '0;
          state_d      = R_IDLE;
          byte_valid_d = rx_sync_q;
          stop_err_d   = !rx_sync_q;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  // NOTE: sequential state uses nonblocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= R_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      stop_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      stop_err_q   <= stop_err_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = shift_q;
  assign stop_err   = stop_err_q;

endmodule

// File: rtl/uart_mem_loader.sv
// Receives UART bytes, packs them little-endian into 32-bit words and strobes them into data memory.
// Optional trailing XOR checksum byte when UART_MEM_LOADER_CHECKSUM_EN is defined.
module uart_mem_loader
  import uart_mem_loader_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          NUM_WORDS    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              we,
  output logic [WORD_W-1:0] waddr,
  output logic [WORD_W-1:0] wdata,
  output logic [15:0]       word_count,
  output logic              frame_err,
  output logic              chk_err
);

  localparam logic [15:0] LAST_COUNT = 16'(NUM_WORDS);
  localparam logic [1:0]  LAST_IDX   = 2'(BYTES_PER_WORD - 1);

  logic              byte_valid, stop_err;
  logic [BYTE_W-1:0] byte_data;

  ld_state_t         ld_q, ld_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       buf_q, buf_d;
  logic [15:0]       word_count_q, word_count_d;
  logic              we_q, we_d;
  logic [WORD_W-1:0] waddr_q, waddr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              frame_err_q, frame_err_d;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] xor_q, xor_d;
  logic              chk_err_q, chk_err_d;
`endif

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .stop_err   (stop_err)
  );

  always_comb begin
    ld_d         = ld_q;
    byte_idx_d   = byte_idx_q;
    buf_d        = buf_q;
    word_count_d = word_count_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    frame_err_d  = frame_err_q;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
    xor_d        = xor_q;
    chk_err_d    = chk_err_q;
`endif
    // start wins over everything, including a word write due this cycle.
    if (start) begin
      ld_d         = L_LOAD;
      byte_idx_d   = '0;
      word_count_d = '0;
      frame_err_d  = 1'b0;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
      xor_d        = '0;
      chk_err_d    = 1'b0;
`endif
    end else begin
      unique case (ld_q)
        L_LOAD: begin
          if (word_count_q == LAST_COUNT) begin
`ifdef UART_MEM_LOADER_CHECKSUM_EN
            ld_d = L_CHK;
`else
            ld_d = L_DONE;
`endif
          end else begin
            if (stop_err) frame_err_d = 1'b1;
            if (byte_valid) begin
              byte_idx_d = byte_idx_q + 2'd1;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
              xor_d      = xor_q ^ byte_data;
`endif
              unique case (byte_idx_q)
                2'd0: buf_d[7:0]   = byte_data;
                2'd1: buf_d[15:8]  = byte_data;
                2'd2: buf_d[23:16] = byte_data;
                LAST_IDX: begin
                  we_d         = 1'b1;
                  waddr_d      = BASE_ADDR + WORD_W'({word_count_q, 2'b00});
                  wdata_d      = {byte_data, buf_q};
                  word_count_d = word_count_q + 16'd1;
                end
              endcase
            end
          end
        end
`ifdef UART_MEM_LOADER_CHECKSUM_EN
        L_CHK: begin
          if (stop_err) frame_err_d = 1'b1;
          if (byte_valid) begin
            chk_err_d = (byte_data != xor_q);
            ld_d      = L_DONE;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_q         <= L_IDLE;
      byte_idx_q   <= '0;
      buf_q        <= '0;
      word_count_q <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      frame_err_q  <= 1'b0;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
      xor_q        <= '0;
      chk_err_q    <= 1'b0;
`endif
    end else begin
      ld_q         <= ld_d;
      byte_idx_q   <= byte_idx_d;
      buf_q        <= buf_d;
      word_count_q <= word_count_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
      xor_q        <= xor_d;
      chk_err_q    <= chk_err_d;
`endif
    end
  end

  assign busy       = (ld_q == L_LOAD) || (ld_q == L_CHK);
  assign done       = (ld_q == L_DONE);
  assign we         = we_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign word_count = word_count_q;
  assign frame_err  = frame_err_q;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
  assign chk_err    = chk_err_q;
`else
  assign chk_err    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed bench for uart_mem_loader: two instances (base 0x0 / 2 words, base 0x100 / 1 word) share rx and reset.
// CLKS_PER_BIT is shortened to 64, so the rx glitch is scaled to 20 cycles (below half a bit).
module tb_uart_mem_loader;

  localparam int CPB = 64;

  logic        clk = 1'b0;
  logic        reset, rx, start_a, start_b;
  logic        busy_a, done_a, we_a, frame_err_a, chk_err_a;
  logic [31:0] waddr_a, wdata_a;
  logic [15:0] word_count_a;
  logic        busy_b, done_b, we_b, frame_err_b, chk_err_b;
  logic [31:0] waddr_b, wdata_b;
  logic [15:0] word_count_b;

  int n_cmp = 0;
  int n_mis = 0;
  int we_cnt_a = 0, we_cnt_b = 0, bv_cnt_a = 0;
  logic [31:0] addr_log_a[$], data_log_a[$], addr_log_b[$], data_log_b[$];

  always #5 clk = ~clk;

  uart_mem_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(32'h0000_0000), .NUM_WORDS(2)) u_dut_a (
    .clk(clk), .reset(reset), .rx(rx), .start(start_a), .busy(busy_a), .done(done_a),
    .we(we_a), .waddr(waddr_a), .wdata(wdata_a), .word_count(word_count_a),
    .frame_err(frame_err_a), .chk_err(chk_err_a)
  );

  uart_mem_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(32'h0000_0100), .NUM_WORDS(1)) u_dut_b (
    .clk(clk), .reset(reset), .rx(rx), .start(start_b), .busy(busy_b), .done(done_b),
    .we(we_b), .waddr(waddr_b), .wdata(wdata_b), .word_count(word_count_b),
    .frame_err(frame_err_b), .chk_err(chk_err_b)
  );

  always @(negedge clk) begin
    if (we_a) begin
      we_cnt_a++;
      addr_log_a.push_back(waddr_a);
      data_log_a.push_back(wdata_a);
    end
    if (we_b) begin
      we_cnt_b++;
      addr_log_b.push_back(waddr_b);
      data_log_b.push_back(wdata_b);
    end
    if (u_dut_a.u_rx.byte_valid) bv_cnt_a++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    we_cnt_a = 0; we_cnt_b = 0; bv_cnt_a = 0;
    addr_log_a.delete(); data_log_a.delete();
    addr_log_b.delete(); data_log_b.delete();
  endtask

  task automatic pulse_start(input bit sel_b);
    @(negedge clk);
    if (sel_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  // Sends the trailing checksum byte only when the checksum feature is built.
  task automatic end_session(input logic [7:0] c);
`ifdef UART_MEM_LOADER_CHECKSUM_EN
    send_byte(c, 1'b1);
`else
    if (c === 8'hxx) $display("unused checksum byte");
`endif
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
  endfunction

  initial begin
    reset = 1'b0; rx = 1'b1; start_a = 1'b0; start_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctrl_a", {busy_a, done_a, we_a, frame_err_a, chk_err_a}, 0);
    check("rst_data_a", {waddr_a, wdata_a}, 0);
    check("rst_wc_a", word_count_a, 0);
    check("rst_ctrl_b", {busy_b, done_b, we_b, frame_err_b, chk_err_b}, 0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Two-word session at base 0
    clear_logs();
    pulse_start(1'b0);
    check("t1_busy_armed", busy_a, 1);
    send_word(32'h1234_5678);
    send_word(32'hDEAD_BEEF);
    end_session(8'h2A);
    check("t1_we_cnt", we_cnt_a, 2);
    check("t1_addr0", qget(addr_log_a, 0), 32'h0);
    check("t1_data0", qget(data_log_a, 0), 32'h1234_5678);
    check("t1_addr1", qget(addr_log_a, 1), 32'h4);
    check("t1_data1", qget(data_log_a, 1), 32'hDEAD_BEEF);
    check("t1_done_busy", {done_a, busy_a}, 2'b10);
    check("t1_wc", word_count_a, 2);
    check("t1_chk_err", chk_err_a, 0);
    check("t1_b_ignored", we_cnt_b, 0);

    // One-word session at base 0x100
    clear_logs();
    pulse_start(1'b1);
    send_word(32'h0403_0201);
    end_session(8'h04);
    check("t2_we_cnt", we_cnt_b, 1);
    check("t2_addr", qget(addr_log_b, 0), 32'h100);
    check("t2_data", qget(data_log_b, 0), 32'h0403_0201);
    check("t2_done_busy", {done_b, busy_b}, 2'b10);
    check("t2_chk_err", chk_err_b, 0);
    check("t2_a_ignored", we_cnt_a, 0);
`ifdef UART_MEM_LOADER_CHECKSUM_EN
    pulse_start(1'b1);
    send_word(32'h0403_0201);
    end_session(8'h05);
    check("t2_bad_done", done_b, 1);
    check("t2_bad_chk_err", chk_err_b, 1);
`endif

    // Restart discards a partial word
    clear_logs();
    pulse_start(1'b1);
    send_byte(8'h99, 1'b1);
    send_byte(8'h88, 1'b1);
    pulse_start(1'b1);
    check("t4_restart_busy", {done_b, busy_b}, 2'b01);
    check("t4_restart_wc", word_count_b, 0);
    send_word(32'h4433_2211);
    end_session(8'h44);
    check("t4_we_cnt", we_cnt_b, 1);
    check("t4_addr", qget(addr_log_b, 0), 32'h100);
    check("t4_data", qget(data_log_b, 0), 32'h4433_2211);

    // Frame error: 0x55 dropped, session goes on
    clear_logs();
    pulse_start(1'b0);
    send_byte(8'h55, 1'b0);
    check("t3_frame_err", frame_err_a, 1);
    check("t3_no_we_yet", we_cnt_a, 0);
    send_word(32'hDDCC_BBAA);
    check("t3_we_cnt", we_cnt_a, 1);
    check("t3_addr", qget(addr_log_a, 0), 32'h0);
    check("t3_data", qget(data_log_a, 0), 32'hDDCC_BBAA);
    check("t3_state", {busy_a, frame_err_a, word_count_a}, {1'b1, 1'b1, 16'd1});

    // Short low glitch on rx
    clear_logs();
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB / 2 - 12) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("t5_no_byte", bv_cnt_a, 0);
    check("t5_no_we", we_cnt_a + we_cnt_b, 0);
    check("t5_wc", word_count_a, 1);

    // Reset mid-byte
    clear_logs();
    @(negedge clk);
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("t6_ctrl_a", {busy_a, done_a, we_a, frame_err_a, chk_err_a}, 0);
    check("t6_data_a", {waddr_a, wdata_a}, 0);
    check("t6_wc_a", word_count_a, 0);
    check("t6_ctrl_b", {busy_b, done_b, we_b, frame_err_b, chk_err_b}, 0);
    check("t6_data_b", {waddr_b, wdata_b}, 0);
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    send_word(32'hCAFE_F00D);
    check("t6_no_we_after", we_cnt_a + we_cnt_b, 0);
    check("t6_idle", {busy_a, done_a, word_count_a}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
